// File: rtl/mem_copy_dma.sv
// Block-move sequencer driving a single-port memory: RD/WR per word, memmove-safe.
// Define MEM_COPY_VERIFY_EN to add a read-back VF state and a sticky err flag.
module mem_copy_dma #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src,
   input  logic [ADDR_WIDTH-1:0] dst,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
`ifdef MEM_COPY_VERIFY_EN
      S_VF,
`endif
      S_DONE
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] src_r, dst_r, i;
   logic [ADDR_WIDTH:0]   len_r;
   logic                  back_r;

   logic [ADDR_WIDTH-1:0] off, k_first, k_cur, k_nxt, i_nxt;
   logic [ADDR_WIDTH:0]   len_in_m1, len_m1;
   logic                  back_in, last;

   // Backward copy only when dst lands strictly inside the source range.
   always_comb begin
      off       = dst - src;
      back_in   = (off != '0) && ({1'b0, off} < len);
      len_in_m1 = len - (ADDR_WIDTH+1)'(1);
      k_first   = back_in ? len_in_m1[ADDR_WIDTH-1:0] : '0;
      len_m1    = len_r - (ADDR_WIDTH+1)'(1);
      i_nxt     = i + ADDR_WIDTH'(1);
      k_cur     = back_r ? len_m1[ADDR_WIDTH-1:0] - i     : i;
      k_nxt     = back_r ? len_m1[ADDR_WIDTH-1:0] - i_nxt : i_nxt;
      last      = ({1'b0, i} == len_m1);
   end

`ifndef MEM_COPY_VERIFY_EN
   assign err = 1'b0;
`endif

   // mem_din doubles as the data register holding the word read in RD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         src_r    <= '0;
         dst_r    <= '0;
         len_r    <= '0;
         back_r   <= 1'b0;
         i        <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
`ifdef MEM_COPY_VERIFY_EN
         err      <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  src_r  <= src;
                  dst_r  <= dst;
                  len_r  <= len;
                  back_r <= back_in;
                  i      <= '0;
                  busy   <= 1'b1;
`ifdef MEM_COPY_VERIFY_EN
                  err    <= 1'b0;
`endif
                  if (len == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= S_RD;
                     mem_addr <= src + k_first;
                  end
               end
            end
            S_RD: begin
               state    <= S_WR;
               mem_addr <= dst_r + k_cur;
               mem_we   <= 1'b1;
               mem_din  <= mem_dout;
            end
`ifdef MEM_COPY_VERIFY_EN
            S_WR: begin
               mem_we <= 1'b0;
               state  <= S_VF;
            end
            S_VF: begin
               if (mem_dout != mem_din) err <= 1'b1;
`else
            S_WR: begin
               mem_we <= 1'b0;
`endif
               if (last) begin
                  state    <= S_DONE;
                  done     <= 1'b1;
                  mem_addr <= '0;
                  mem_din  <= '0;
               end else begin
                  state    <= S_RD;
                  i        <= i_nxt;
                  mem_addr <= src_r + k_nxt;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Scoreboard bench for mem_copy_dma: expected memory accesses and done timing are
// queued at issue time and checked by an independent monitor each cycle.
module tb_mem_copy_dma;
   localparam int DW = 1;
   localparam int AW = 8;
`ifdef MEM_COPY_VERIFY_EN
   localparam int MUL = 3;
`else
   localparam int MUL = 2;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] src, dst;
   logic [AW:0]   len;
   logic          busy, done, err, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din, mem_dout;

   mem_copy_dma #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
      .busy(busy), .done(done), .err(err), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // memory model with preload port and an optional stuck-at-0 word
   logic [DW-1:0] mem [0:255];
   logic          clr_en = 1'b0, poke_en = 1'b0;
   logic [AW-1:0] poke_addr = '0;
   logic [DW-1:0] poke_val = '0;
   int            stuck_addr = -1;
   assign mem_dout = mem[mem_addr];
   always @(posedge clk) begin
      if (clr_en) begin
         for (int a = 0; a < 256; a++) mem[a] <= '0;
      end else if (poke_en) begin
         mem[poke_addr] <= poke_val;
      end else if (mem_we) begin
         mem[mem_addr] <= (int'(mem_addr) == stuck_addr) ? '0 : mem_din;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0, miscompares = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {logic [AW-1:0] addr; logic we; logic [DW-1:0] din;} acc_t;
   acc_t aq[$];
   int   dq[$];

   // monitor: every busy non-done cycle is one memory access
   always @(negedge clk) begin
      if (!rst) begin
         if (busy && !done) begin
            if (aq.size() == 0) chk("acc_unexpected", 32'(mem_addr), 32'hFFFF);
            else begin
               acc_t e;
               e = aq.pop_front();
               chk("acc_addr", 32'(mem_addr), 32'(e.addr));
               chk("acc_we", 32'(mem_we), 32'(e.we));
               if (e.we) chk("acc_din", 32'(mem_din), 32'(e.din));
            end
         end else if (mem_we) chk("idle_we", 32'(mem_we), 0);
         if (done) begin
            if (dq.size() == 0) chk("done_unexpected", cyc, -1);
            else chk("done_cyc", cyc, dq.pop_front());
         end
      end
   end

   int t0;

   task automatic poke(input int a, input int v);
      @(negedge clk);
      poke_en = 1'b1; poke_addr = AW'(a); poke_val = DW'(v);
      @(posedge clk); #1 poke_en = 1'b0;
   endtask

   task automatic start_copy(input int s, input int d, input int l);
      @(negedge clk);
      src = AW'(s); dst = AW'(d); len = (AW+1)'(l); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; src = 8'h5A; dst = 8'hA5; len = 9'd3;
      t0 = cyc;
   endtask

   // back is given by hand per vector; data comes from the pre-copy memory image
   task automatic push_copy(input int s, input int d, input int l, input bit back);
      for (int i = 0; i < l; i++) begin
         int k;
         acc_t e;
         k = back ? l - 1 - i : i;
         e.addr = AW'(s + k); e.we = 1'b0; e.din = '0; aq.push_back(e);
         e.din = mem[AW'(s + k)];
         e.addr = AW'(d + k); e.we = 1'b1; aq.push_back(e);
         if (MUL == 3) begin e.we = 1'b0; e.din = '0; aq.push_back(e); end
      end
      dq.push_back(t0 + MUL * l);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 2000) begin @(negedge clk); n++; end
      if (busy) chk({name, "_timeout"}, 32'(busy), 0);
      chk({name, "_aq_empty"}, aq.size(), 0);
      chk({name, "_dq_empty"}, dq.size(), 0);
   endtask

   task automatic chk_mem(input string name, input int a, input int v);
      chk(name, 32'(mem[AW'(a)]), 32'(v));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
      @(negedge clk); clr_en = 1'b1;
      @(negedge clk); clr_en = 1'b0;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_din", 32'(mem_din), 0);
      rst = 1'b0;

      // forward copy
      poke(8'h10, 1); poke(8'h11, 0); poke(8'h12, 1); poke(8'h13, 1);
      start_copy(8'h10, 8'h40, 4);
      push_copy(8'h10, 8'h40, 4, 1'b0);
      @(negedge clk); chk("fwd_busy_c1", 32'(busy), 1);
      wait_idle("fwd");
      chk_mem("fwd_d0", 8'h40, 1); chk_mem("fwd_d1", 8'h41, 0);
      chk_mem("fwd_d2", 8'h42, 1); chk_mem("fwd_d3", 8'h43, 1);
      chk_mem("fwd_s1", 8'h11, 0); chk_mem("fwd_s3", 8'h13, 1);

      // overlapping backward copy; first access reads 0x13, first write 0x15
      poke(8'h12, 0); poke(8'h13, 1);
      start_copy(8'h10, 8'h12, 4);
      push_copy(8'h10, 8'h12, 4, 1'b1);
      wait_idle("bwd");
      chk_mem("bwd_d0", 8'h12, 1); chk_mem("bwd_d1", 8'h13, 0);
      chk_mem("bwd_d2", 8'h14, 0); chk_mem("bwd_d3", 8'h15, 1);

      // zero length
      start_copy(8'h30, 8'h50, 0);
      dq.push_back(t0);
      @(negedge clk); chk("zero_done_c1", 32'(done), 1);
      wait_idle("zero");

      // start during an active copy is ignored; 0x10..0x13 now 1,0,1,0
      start_copy(8'h10, 8'h60, 4);
      push_copy(8'h10, 8'h60, 4, 1'b0);
      @(negedge clk); @(negedge clk);
      start = 1'b1; src = 8'h00; dst = 8'h70; len = 9'd4;
      @(negedge clk); start = 1'b0;
      wait_idle("ign");
      chk_mem("ign_d0", 8'h60, 1); chk_mem("ign_d1", 8'h61, 0);
      chk_mem("ign_d2", 8'h62, 1); chk_mem("ign_d3", 8'h63, 0);
      chk_mem("ign_none", 8'h71, 0);

      // wrap-around of the source range
      poke(8'hFE, 1); poke(8'hFF, 1); poke(8'h00, 0); poke(8'h01, 1);
      start_copy(8'hFE, 8'h20, 4);
      push_copy(8'hFE, 8'h20, 4, 1'b0);
      wait_idle("wrap");
      chk_mem("wrap_d0", 8'h20, 1); chk_mem("wrap_d1", 8'h21, 1);
      chk_mem("wrap_d2", 8'h22, 0); chk_mem("wrap_d3", 8'h23, 1);

      // reset asserted in the second WR cycle
      poke(8'h80, 1); poke(8'h81, 1); poke(8'h82, 1); poke(8'h83, 1);
      start_copy(8'h80, 8'h90, 4);
      push_copy(8'h80, 8'h90, 4, 1'b0);
      repeat (MUL + 1) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_busy", 32'(busy), 0);
      chk("mid_we", 32'(mem_we), 0);
      chk("mid_addr", 32'(mem_addr), 0);
      chk("mid_din", 32'(mem_din), 0);
      chk("mid_done", 32'(done), 0);
      aq.delete(); dq.delete();
      @(negedge clk); @(negedge clk); rst = 1'b0;
      chk_mem("mid_w0", 8'h90, 1); chk_mem("mid_w1", 8'h91, 0);
      start_copy(8'h80, 8'h98, 1);
      push_copy(8'h80, 8'h98, 1, 1'b0);
      wait_idle("after_rst");
      chk_mem("after_rst_d0", 8'h98, 1);

`ifdef MEM_COPY_VERIFY_EN
      // read-back mismatch on dst+1
      poke(8'hB0, 1); poke(8'hB1, 1); poke(8'hB2, 1); poke(8'hB3, 1);
      stuck_addr = 8'hA1;
      start_copy(8'hB0, 8'hA0, 4);
      push_copy(8'hB0, 8'hA0, 4, 1'b0);
      repeat (6) @(negedge clk);
      chk("vf_err_c6", 32'(err), 0);
      @(negedge clk);
      chk("vf_err_c7", 32'(err), 1);
      wait_idle("vf");
      chk("vf_err_end", 32'(err), 1);
      chk_mem("vf_stuck", 8'hA1, 0);
      stuck_addr = -1;
      start_copy(8'h00, 8'h00, 0);
      dq.push_back(t0);
      @(negedge clk); chk("vf_err_clr", 32'(err), 0);
      wait_idle("vf_clr");
`endif
      chk("final_err", 32'(err), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Sequencer that sits directly upstream of the single-port `Memory` array and owns its `addr`/`we`/`din` pins. On a start pulse it copies `len` words from a source address to a destination address, reading through the array's combinational `dout`. Overlapping ranges get memmove semantics. It gives the CA1 datapath a block-move primitive without adding a second memory port.

## Interface
- `DATA_WIDTH`, 1, word width; must match the memory.
- `ADDR_WIDTH`, 8, address width; must match the memory.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `src`  in  ADDR_WIDTH  source base address; captured with `start`.
- `dst`  in  ADDR_WIDTH  destination base address; captured with `start`.
- `len`  in  ADDR_WIDTH+1  word count, 0 to 2^ADDR_WIDTH; captured with `start`.
- `busy`  out  1  high from the cycle after accepted `start` through the DONE cycle.
- `done`  out  1  one-cycle pulse in the DONE state.
- `err`  out  1  sticky verify-mismatch flag. Stays 0 without `MEM_COPY_VERIFY_EN`.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_we`  out  1  memory write enable.
- `mem_din`  out  DATA_WIDTH  memory write data.
- `mem_dout`  in  DATA_WIDTH  memory combinational read data.

## Operation
- States: IDLE, RD, WR, VF (only with the macro), DONE.
- **IDLE**
  - `start`=1 latches `src`, `dst` and `len`, sets counter i=0 and clears `err`.
  - If `len`==0, go to DONE; otherwise go to RD.
- **Direction** is decided once, at start.
  - off = (dst − src) mod 2^ADDR_WIDTH.
  - If 0 < off < len, copy backward: element k = len−1−i.
  - Otherwise copy forward: k = i.
- **RD**: `mem_addr` = src+k; `mem_dout` is captured into a data register at the clock edge. Next state is WR.
- **WR**: `mem_addr` = dst+k, `mem_we`=1, `mem_din` = data register. Next state:
  - VF if the macro is defined;
  - else DONE if i==len−1;
  - else i++ and RD.
- **DONE**: `done`=1, `busy`=1, then IDLE.
- **Address arithmetic** is modulo 2^ADDR_WIDTH; ranges wrap silently past the top address.
- `dst`==`src` is a legal copy: every word is rewritten with itself.
- `start` outside IDLE is ignored. Inputs may change after acceptance without effect.
- In IDLE and DONE: `mem_we`=0, `mem_addr`=0, `mem_din`=0.
- `mem_we` is decoded only from the registered state and is glitch-free.

## Timing
- **Reset values**: state IDLE; `busy`, `done`, `err`, `mem_we`, `mem_addr`, `mem_din`, counter and data register all 0.
- **Reset mid-operation**: outputs go to reset values immediately (asynchronous). Words already written stay written. No further writes occur.
- **Per word**: 2 cycles (RD, WR), or 3 with the macro (RD, WR, VF).
- **Start to `done`**:
  - accepted `start` edge → first RD cycle;
  - `done` is high in cycle 2·len+1 after the accepting edge (3·len+1 with the macro);
  - `len`==0 gives `done` in cycle 1.
- A new `start` is accepted in the cycle after DONE at the earliest.
- Memory writes land on the clock edge that ends each WR cycle.

## Configuration
- `MEM_COPY_VERIFY_EN` defined:
  - adds state VF after every WR, with `mem_addr` = dst+k and `mem_we`=0;
  - if `mem_dout` ≠ data register, `err` is set and stays high until the next accepted `start` or reset;
  - the copy always runs to completion; `err` does not abort it.
- Not defined: no VF state, `err` is tied to 0, and throughput is 2 cycles per word.

## Test plan
- **Forward copy**: memory preloaded 0x10–0x13 = 1,0,1,1; `start` with src=0x10, dst=0x40, len=4 → 0x40–0x43 = 1,0,1,1. `done` pulses at cycle 9, `busy` is high cycles 1–9, and 0x10–0x13 are unchanged.
- **Overlapping backward copy**: 0x10–0x13 = 1,0,0,1; src=0x10, dst=0x12, len=4 → 0x12–0x15 = 1,0,0,1. The first write goes to 0x15.
- **Zero length and ignored start**: len=0 → `done` at cycle 1 and no `mem_we`. A second `start` with src=0x00 pulsed during a len=4 copy → ignored; the original copy completes and no extra `done` appears.
- **Wrap-around**: src=0xFE, dst=0x20, len=4 → reads 0xFE, 0xFF, 0x00, 0x01 in order; writes 0x20–0x23.
- **Reset mid-operation**: `rst` asserted during the second WR of a len=4 copy → all outputs 0 in the same cycle, only dst+0 written, state IDLE, and a new `start` is accepted afterwards.
- **Verify mismatch (with macro)**: force the bit at dst+1 stuck at 0 while copying a 1 → `err`=1 after that VF cycle. `done` still appears at cycle 13 for len=4, and the next `start` clears `err`.
